// File: rtl/grouped_update_sequencer.sv
// grouped_update_sequencer: steps the LUT group index through colour groups with a programmable dwell per group
// and pauses between sweeps for a sampler handshake.
module grouped_update_sequencer #(
    parameter int NUM_GROUPS = 5,
    parameter int DWELL_W    = 8,
    parameter int SWEEP_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic               sample_ack,
    output logic [0:2]         group_EN,
    output logic               update_en,
    output logic               sample_req,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RUN, SAMPLE, DONE} state_t;

    localparam logic [2:0] LAST = 3'(NUM_GROUPS - 1);

    state_t             state;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SWEEP_W-1:0] target;
    logic [DWELL_W-1:0] dwell_eff;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // dwell_cnt counts the cycles left in the current group after this one
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dwell_lat  <= '0;
            dwell_cnt  <= '0;
            target     <= '0;
            group_EN   <= '0;
            update_en  <= 1'b0;
            sample_req <= 1'b0;
            sweep_done <= 1'b0;
            sweep_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state     <= RUN;
                        dwell_lat <= dwell_eff;
                        dwell_cnt <= dwell_eff - DWELL_W'(1);
                        target    <= num_sweeps;
                        sweep_cnt <= '0;
                        group_EN  <= '0;
                        update_en <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        group_EN  <= '0;
                        update_en <= 1'b0;
                        busy      <= 1'b0;
                    end else if (dwell_cnt == '0) begin
                        if (group_EN < LAST) begin
                            group_EN  <= group_EN + 3'd1;
                            dwell_cnt <= dwell_lat - DWELL_W'(1);
                        end else begin
                            state      <= SAMPLE;
                            update_en  <= 1'b0;
                            sample_req <= 1'b1;
                            sweep_done <= 1'b1;
                            sweep_cnt  <= sweep_cnt + SWEEP_W'(1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                SAMPLE: begin
                    if (stop) begin
                        state      <= IDLE;
                        group_EN   <= '0;
                        sample_req <= 1'b0;
                        busy       <= 1'b0;
                    end else if (sample_ack) begin
                        sample_req <= 1'b0;
                        group_EN   <= '0;
                        if (target != '0 && sweep_cnt == target) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            update_en <= 1'b1;
                            dwell_cnt <= dwell_lat - DWELL_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grouped_update_sequencer.sv
// tb_grouped_update_sequencer: vector table plus randomized run checked against a sweep-level reference model.
module tb_grouped_update_sequencer;
    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst, start, stop, sample_ack;
    logic [7:0]  dwell;
    logic [15:0] num_sweeps;

    logic [0:2]  a_grp, b_grp;
    logic        a_upd, a_req, a_sd, a_busy, a_done;
    logic        b_upd, b_req, b_sd, b_busy, b_done;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    grouped_update_sequencer u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
        .num_sweeps(num_sweeps), .sample_ack(sample_ack), .group_EN(a_grp),
        .update_en(a_upd), .sample_req(a_req), .sweep_done(a_sd),
        .sweep_cnt(a_cnt), .busy(a_busy), .done(a_done)
    );

    grouped_update_sequencer #(.SWEEP_W(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
        .num_sweeps(num_sweeps[2:0]), .sample_ack(sample_ack), .group_EN(b_grp),
        .update_en(b_upd), .sample_req(b_req), .sweep_done(b_sd),
        .sweep_cnt(b_cnt), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 run, 2 sample, 3 done; r is the run-cycle index within the sweep
    int          m_mode = 0, m_r = 0, m_d = 1;
    logic [15:0] m_tgt = '0, m_cnt = '0;
    logic        m_sd = 1'b0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_sd = 1'b0;
        if (rst) begin
            m_mode = 0;
            m_cnt  = '0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (stop) m_mode = 0;
            else if (start) begin
                m_mode = 1; m_r = 0; m_d = (dwell == 0) ? 1 : int'(dwell);
                m_tgt = num_sweeps; m_cnt = '0;
            end
        end else if (m_mode == 1) begin
            if (stop) m_mode = 0;
            else if (m_r == N * m_d - 1) begin m_mode = 2; m_cnt++; m_sd = 1'b1; end
            else m_r++;
        end else begin
            if (stop) m_mode = 0;
            else if (sample_ack) begin
                if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 3;
                else begin m_mode = 1; m_r = 0; end
            end
        end
    endtask

    task automatic chk_all();
        int eg;
        eg = (m_mode == 1) ? m_r / m_d : (m_mode == 2) ? N - 1 : 0;
        check("grp",  32'(a_grp),  32'(eg));
        check("upd",  32'(a_upd),  32'(m_mode == 1));
        check("req",  32'(a_req),  32'(m_mode == 2));
        check("sd",   32'(a_sd),   32'(m_sd));
        check("cnt",  32'(a_cnt),  32'(m_cnt));
        check("busy", 32'(a_busy), 32'(m_mode == 1 || m_mode == 2));
        check("done", 32'(a_done), 32'(m_mode == 3));
        check("w3_grp", 32'(b_grp), 32'(eg));
        check("w3_upd", 32'(b_upd), 32'(m_mode == 1));
        check("w3_sd",  32'(b_sd),  32'(m_sd));
        check("w3_cnt", 32'(b_cnt), 32'(m_cnt[2:0]));
        check("w3_done", 32'(b_done), 32'(m_mode == 3));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic set_in(input logic st, input logic sp, input logic ak,
                          input logic [7:0] dw, input logic [15:0] ns);
        start = st; stop = sp; sample_ack = ak; dwell = dw; num_sweeps = ns;
    endtask

    typedef struct {
        logic        st, sp, ak;
        logic [7:0]  dw;
        logic [15:0] ns;
        logic [2:0]  g;
        logic        u, rq, sd, b, dn;
        logic [15:0] c;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int pulses, stall, prev_b;
        logic found, saw_wrap;
        tbl[0]  = '{1, 0, 1, 2, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 2, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 2, 1, 1, 1, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 2, 1, 1, 1, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 1, 2, 1, 2, 1, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 2, 1, 2, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 1, 2, 1, 4, 1, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 2, 1, 4, 1, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 2, 1, 4, 0, 1, 1, 1, 0, 1};
        tbl[11] = '{0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[12] = '{1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 1, 0, 3, 0, 1, 0, 0, 1, 0, 0};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].st, tbl[i].sp, tbl[i].ak, tbl[i].dw, tbl[i].ns);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {13'(a_grp), a_upd, a_req, a_sd, a_busy, a_done, a_cnt},
                  {13'(tbl[i].g), tbl[i].u, tbl[i].rq, tbl[i].sd, tbl[i].b, tbl[i].dn, tbl[i].c});
        end

        // dwell 0, three back-to-back sweeps
        set_in(0, 0, 1, 0, 3);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            pulses += int'(a_sd);
        end
        check("b2b_pulses", 32'(pulses), 32'd3);
        check("b2b_done", {31'd0, a_done}, 32'd1);
        check("b2b_cnt", 32'(a_cnt), 32'd3);

        // ack stall
        set_in(0, 1, 0, 1, 2); step();
        set_in(1, 0, 0, 1, 2); step();
        start = 1'b0;
        for (int i = 0; i < 20 && m_mode != 2; i++) step();
        stall = (a_req && !a_upd && a_grp == 3'd4) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_req && !a_upd && a_grp == 3'd4) stall++;
        end
        check("stall_cycles", 32'(stall), 32'd7);
        sample_ack = 1'b1; step();
        check("stall_resume", {28'd0, a_upd, 3'(a_grp)}, 32'h8);

        // stop in dwell cycle 1 of group 2 on sweep 5, free-run
        set_in(0, 1, 1, 2, 0); step();
        set_in(1, 0, 1, 2, 0); step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            found = (m_mode == 1 && m_r / m_d == 2 && m_r % m_d == 1 && m_cnt == 4);
        end
        check("stop_found", {31'd0, found}, 32'd1);
        stop = 1'b1; step();
        check("stop_state", {a_upd, a_busy, a_req, 13'd0, a_cnt}, 32'd4);
        set_in(1, 0, 1, 2, 0); step();
        check("restart", {a_upd, 3'(a_grp), 12'd0, a_cnt}, 32'h8000_0000);

        // free-run wrap on the 3-bit counter, start mid-run ignored
        set_in(0, 1, 1, 1, 0); step();
        set_in(1, 0, 1, 1, 0); step();
        start = 1'b0;
        saw_wrap = 1'b0;
        prev_b = 0;
        for (int i = 0; i < 60; i++) begin
            start = (i == 13);
            step();
            if (prev_b == 7 && b_cnt == 3'd0 && b_sd) saw_wrap = 1'b1;
            prev_b = int'(b_cnt);
        end
        check("wrap_seen", {31'd0, saw_wrap}, 32'd1);

        // reset held 3 cycles mid-run, then a fresh start
        set_in(0, 1, 1, 3, 0); step();
        set_in(1, 0, 1, 3, 0); step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_zero", {a_upd, a_req, a_sd, a_busy, a_done, 3'(a_grp), 8'd0, a_cnt}, 32'd0);
        rst = 1'b0;
        set_in(1, 0, 1, 3, 0); step();
        check("rst_restart", {31'd0, a_upd}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            set_in($urandom_range(7) == 0, $urandom_range(31) == 0, $urandom_range(1) == 1,
                   8'($urandom_range(3)), 16'($urandom_range(3)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
